// File: rtl/event_framer.sv
// event_framer: rings N_CH sample streams, captures PRE/POST windows around trigger edges, frames them as header + packed 64-bit words.
// Latency: first FIFO write exactly POST cycles after the trigger cycle, then one word per cycle while full_i is low.
// Backpressure: full_i holds din_o and freezes emission; triggers while busy are dropped and counted. Macro EVENT_FRAMER_TIMESTAMP_EN adds a timestamp word.
module event_framer #(
    parameter int N_CH     = 2,
    parameter int SAMPLE_W = 16,
    parameter int PRE      = 8,
    parameter int POST     = 8,
    parameter int DEPTH    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trig_i,
    input  logic [N_CH*SAMPLE_W-1:0] samples_i,
    input  logic                     full_i,
    output logic                     wr_en_o,
    output logic [63:0]              din_o,
    output logic                     busy_o,
    output logic [31:0]              event_cnt_o,
    output logic [15:0]              drop_cnt_o
);

    localparam int PACK   = 64 / SAMPLE_W;
    localparam int WIN    = PRE + POST;
    localparam int NWORDS = WIN / PACK;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int NR     = 1 << CW;
    localparam int WW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_POST, S_HDR, S_TS, S_DRAIN} state_t;

    state_t              state, state_nxt;
    logic [SAMPLE_W-1:0] ring [NR][DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       trig_addr;
    logic [AW-1:0]       win_start;
    logic [15:0]         arm_cnt;
    logic [15:0]         post_cnt;
    logic [CW-1:0]       drain_ch;
    logic [WW-1:0]       drain_w;
    logic                trig_q;
    logic                trig_rise;
    logic                armed;
    logic                accept;
    logic                ring_we;
    logic                pending;
    logic                last_in_ch;
    logic                last_word;
    logic [63:0]         header_word;
    logic [63:0]         data_word;

    assign trig_rise   = trig_i && !trig_q;
    assign armed       = (arm_cnt >= 16'(PRE));
    assign accept      = (state == S_IDLE) && trig_rise && armed;
    assign ring_we     = (state == S_IDLE) || (state == S_POST);
    assign win_start   = trig_addr - AW'(PRE);
    assign last_in_ch  = (drain_w == WW'(NWORDS - 1));
    assign last_word   = last_in_ch && (drain_ch == CW'(N_CH - 1));
    assign header_word = {8'hA5, 8'(N_CH), 16'(WIN), event_cnt_o};

`ifdef EVENT_FRAMER_TIMESTAMP_EN
    logic [63:0] cycle_cnt;
    logic [63:0] ts_q;

    // Free-running cycle counter, snapshotted on the accepted trigger cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            ts_q      <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (accept) ts_q <= cycle_cnt;
        end
    end
`endif

    // Sample rings: written every cycle while capturing, frozen while framing
    always_ff @(posedge clk) begin
        if (ring_we) begin
            for (int c = 0; c < N_CH; c++) begin
                ring[c][wr_ptr] <= samples_i[c*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    // Gather PACK consecutive samples of the current channel, earliest in the low bits
    always_comb begin
        data_word = '0;
        for (int k = 0; k < PACK; k++) begin
            data_word[k*SAMPLE_W +: SAMPLE_W] =
                ring[drain_ch][win_start + AW'(int'(drain_w) * PACK + k)];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; framing states only advance when the FIFO accepts a word
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = (POST > 1) ? S_POST : S_HDR;
            S_POST:  if (post_cnt == 16'(POST - 1)) state_nxt = S_HDR;
`ifdef EVENT_FRAMER_TIMESTAMP_EN
            S_HDR:   if (!full_i) state_nxt = S_TS;
            S_TS:    if (!full_i) state_nxt = S_DRAIN;
`else
            S_HDR:   if (!full_i) state_nxt = S_DRAIN;
`endif
            S_DRAIN: if (!full_i && last_word) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs: the pending word is a pure function of state, so it holds under full_i
    always_comb begin
        busy_o  = (state != S_IDLE);
        pending = (state == S_HDR) || (state == S_TS) || (state == S_DRAIN);
        wr_en_o = pending && !full_i;
        din_o   = '0;
        case (state)
            S_HDR:   din_o = header_word;
`ifdef EVENT_FRAMER_TIMESTAMP_EN
            S_TS:    din_o = ts_q;
`endif
            S_DRAIN: din_o = data_word;
            default: din_o = '0;
        endcase
    end

    // Datapath: write pointer, arming, trigger latch, drain cursor and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_q      <= 1'b0;
            wr_ptr      <= '0;
            arm_cnt     <= '0;
            trig_addr   <= '0;
            post_cnt    <= '0;
            drain_ch    <= '0;
            drain_w     <= '0;
            event_cnt_o <= '0;
            drop_cnt_o  <= '0;
        end else begin
            trig_q <= trig_i;
            if (ring_we) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (!armed) arm_cnt <= arm_cnt + 16'd1;
            end
            if (accept) begin
                trig_addr <= wr_ptr;
                post_cnt  <= 16'd1;
            end
            if (state == S_POST) post_cnt <= post_cnt + 16'd1;
            if (busy_o && trig_rise && (drop_cnt_o != 16'hFFFF)) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
            if ((state == S_DRAIN) && wr_en_o) begin
                if (last_in_ch) begin
                    drain_w  <= '0;
                    drain_ch <= drain_ch + CW'(1);
                end else begin
                    drain_w <= drain_w + WW'(1);
                end
                if (last_word) begin
                    drain_ch    <= '0;
                    event_cnt_o <= event_cnt_o + 32'd1;
                    arm_cnt     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_event_framer.sv
// Bench for event_framer at default parameters: scoreboard of expected FIFO words checked by a negedge monitor.
// Covers reset values, unarmed trigger, first-event latency, ring wrap, backpressure with drop, mid-event reset.
// Define EVENT_FRAMER_TIMESTAMP_EN for both files to check the timestamp word as well.
module tb_event_framer;

`ifdef EVENT_FRAMER_TIMESTAMP_EN
    localparam int TSW = 1;
`else
    localparam int TSW = 0;
`endif
    localparam int NW_CH  = 4;          // 16 samples of 16 bits per channel -> 4 words
    localparam int NW_TOT = 2 * NW_CH;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trig = 1'b0;
    logic [31:0] samples = '0;
    logic        full = 1'b0;
    logic        wr_en;
    logic [63:0] din;
    logic        busy;
    logic [31:0] event_cnt;
    logic [15:0] drop_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int rel_cyc = 0;

    logic [63:0] exp_q [$];
    int          cyc_q [$];

    event_framer dut (
        .clk         (clk),
        .reset       (reset),
        .trig_i      (trig),
        .samples_i   (samples),
        .full_i      (full),
        .wr_en_o     (wr_en),
        .din_o       (din),
        .busy_o      (busy),
        .event_cnt_o (event_cnt),
        .drop_cnt_o  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock: inputs change 1 ns after the edge; channel c carries {c, cycle[7:0]}
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        samples = {8'd1, 8'(cyc), 8'd0, 8'(cyc)};
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            step();
            if (!busy) return;
        end
        n_total++;
        $display("FAIL %s: busy still high after 200 cycles", name);
    endtask

    // Expected words for a trigger in cycle t; window is cycles t-8 .. t+7
    task automatic push_event(input int t, input logic [31:0] evn, input int ndata, input bit timed);
        int          c0;
        logic [63:0] w;
        c0 = timed ? t + 8 : -1;
        exp_q.push_back({32'hA502_0010, evn});
        cyc_q.push_back(c0);
        if (TSW == 1) begin
            exp_q.push_back(64'(t - rel_cyc));
            cyc_q.push_back(timed ? c0 + 1 : -1);
        end
        for (int i = 0; i < ndata; i++) begin
            int ch;
            int wi;
            ch = i / NW_CH;
            wi = i % NW_CH;
            w  = '0;
            for (int k = 0; k < 4; k++) begin
                w[k*16 +: 16] = {8'(ch), 8'(t - 8 + wi * 4 + k)};
            end
            exp_q.push_back(w);
            cyc_q.push_back(timed ? c0 + TSW + 1 + i : -1);
        end
    endtask

    // Monitor: every written word must match the head of the scoreboard
    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_word: got %h with scoreboard empty (cycle %0d)", din, cyc);
            end else begin
                logic [63:0] e;
                int          ec;
                e  = exp_q.pop_front();
                ec = cyc_q.pop_front();
                chk("word", din, e);
                if (ec >= 0) chk("word_cycle", 64'(cyc), 64'(ec));
            end
        end
    end

    initial begin
        int t;
        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_din", din, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_event_cnt", 64'(event_cnt), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        reset = 1'b0;
        rel_cyc = cyc;

        // Trigger while still unarmed: ignored, not counted
        repeat (3) step();
        trig = 1'b1;
        step();
        trig = 1'b0;
        repeat (16) step();
        @(negedge clk);
        chk("unarmed_busy", 64'(busy), 64'd0);
        chk("unarmed_drop", 64'(drop_cnt), 64'd0);

        // Event 1: no backpressure, exact latency and consecutive words
        trig = 1'b1;
        t = cyc;
        push_event(t, 32'd0, NW_TOT, 1'b1);
        step();
        trig = 1'b0;
        wait_idle("event1_done");
        @(negedge clk);
        chk("event1_cnt", 64'(event_cnt), 64'd1);
        chk("event1_drained", 64'(exp_q.size()), 64'd0);

        // Event 2: window wraps past ring address 0; stall 5 cycles, trigger during drain
        repeat (9) step();
        trig = 1'b1;
        t = cyc;
        push_event(t, 32'd1, NW_TOT, 1'b0);
        step();
        trig = 1'b0;
        repeat (9 + TSW) step();
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            trig = (i == 1);
            @(negedge clk);
            chk("stall_wr_en", 64'(wr_en), 64'd0);
            chk("stall_din", din, exp_q[0]);
            step();
        end
        full = 1'b0;
        trig = 1'b0;
        wait_idle("event2_done");
        @(negedge clk);
        chk("event2_cnt", 64'(event_cnt), 64'd2);
        chk("drain_drop", 64'(drop_cnt), 64'd1);
        chk("event2_drained", 64'(exp_q.size()), 64'd0);

        // Event 3: reset right after the third data word is written
        repeat (9) step();
        trig = 1'b1;
        t = cyc;
        push_event(t, 32'd2, 3, 1'b1);
        step();
        trig = 1'b0;
        repeat (10 + TSW) step();
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_wr_en", 64'(wr_en), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_event_cnt", 64'(event_cnt), 64'd0);
        chk("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("midrst_drained", 64'(exp_q.size()), 64'd0);
        step();
        reset = 1'b0;
        rel_cyc = cyc;

        // Event 4: numbering restarts at 0 after reset
        repeat (10) step();
        trig = 1'b1;
        t = cyc;
        push_event(t, 32'd0, NW_TOT, 1'b1);
        step();
        trig = 1'b0;
        wait_idle("event4_done");
        repeat (5) step();
        @(negedge clk);
        chk("event4_cnt", 64'(event_cnt), 64'd1);
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/event_framer.md
EVENT_FRAMER -- requirements
Module: event_framer

Interface
REQ-001 Parameter N_CH, default 2: number of sampled channels, legal range 1..4.
REQ-002 Parameter SAMPLE_W, default 16: bits per sample, legal values 8, 16 or 32; PACK = 64/SAMPLE_W samples per output word.
REQ-003 Parameter PRE, default 8: samples kept before the trigger sample.
REQ-004 Parameter POST, default 8: samples kept from the trigger sample onward; PRE+POST SHALL be a multiple of PACK.
REQ-005 Parameter DEPTH, default 32: ring depth per channel, power of two, at least PRE+POST.
REQ-006 clk  in  1  single sample/system clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 trig_i  in  1  trigger level from the discriminator; only its rising edge is used.
REQ-009 samples_i  in  N_CH*SAMPLE_W  one sample per channel per cycle; channel c occupies bits [c*SAMPLE_W +: SAMPLE_W].
REQ-010 full_i  in  1  downstream FIFO full.
REQ-011 wr_en_o  out  1  FIFO write strobe.
REQ-012 din_o  out  64  FIFO write data.
REQ-013 busy_o  out  1  high outside IDLE.
REQ-014 event_cnt_o  out  32  events fully written to the FIFO.
REQ-015 drop_cnt_o  out  16  triggers rejected, saturating.

Function
REQ-016 The block SHALL write samples_i into a per-channel ring of DEPTH entries every cycle in IDLE and POST; the ring is frozen in HEADER and DRAIN.
REQ-017 The block SHALL become armed once PRE samples have been written since leaving reset or DRAIN; an unarmed IDLE ignores triggers without counting them.
REQ-018 A rising edge of trig_i (trig_i high, previous cycle low) in armed IDLE SHALL make that cycle's sample the trigger sample (window index PRE), latch its ring address, and enter POST.
REQ-019 POST SHALL last POST-1 further cycles, then go to HEADER; for POST=1 it goes to HEADER directly after the trigger cycle.
REQ-020 HEADER SHALL emit one word: [63:56]=8'hA5, [55:48]=N_CH, [47:32]=PRE+POST, [31:0]=event_cnt_o value before increment.
REQ-021 DRAIN SHALL emit N_CH*(PRE+POST)/PACK data words, channel 0 first, oldest sample first within a channel, earliest sample in the lowest bits of each word.
REQ-022 wr_en_o SHALL be high only in a cycle where a word is pending and full_i is low; while full_i is high, din_o and the pending word are held and nothing advances.
REQ-023 After the last data word is written, event_cnt_o SHALL increment by 1 (wrapping at 2^32), the arm count clears, and the state returns to IDLE.
REQ-024 A trigger rising edge while busy_o is high SHALL increment drop_cnt_o, saturating at 16'hFFFF, and otherwise be ignored.
REQ-025 Ring addressing SHALL wrap modulo DEPTH; a window straddling address 0 is read out in time order.
REQ-026 Without backpressure, the first wr_en_o SHALL occur exactly POST cycles after the trigger cycle, with one word per cycle thereafter.

Reset
REQ-027 With reset high at a clock edge, the block SHALL go to IDLE unarmed and drive wr_en_o=0, din_o=0, busy_o=0, event_cnt_o=0 and drop_cnt_o=0 from the next cycle.
REQ-028 Reset mid-event SHALL discard the partial event; no further words of it are written.

Configuration
REQ-029 With macro EVENT_FRAMER_TIMESTAMP_EN defined, a free-running 64-bit cycle counter SHALL be latched at the trigger cycle and emitted as one extra word right after the header, under the same full_i rule.
REQ-030 Without EVENT_FRAMER_TIMESTAMP_EN, no counter exists and an event is header plus data words only.

Verification
REQ-031 Defaults; samples_i channel c = {c[7:0], cycle[7:0]}; one trigger after 20 cycles with full_i=0 -> 9 consecutive words: header 64'hA502_0010_0000_0000, then 4 words for channel 0 and 4 for channel 1, each carrying 16 consecutive samples ending 7 cycles after the trigger; event_cnt_o=1.
REQ-032 full_i held high for 5 cycles during DRAIN -> wr_en_o=0 for those 5 cycles, din_o stable, no word lost or duplicated.
REQ-033 Trigger 3 cycles after reset release -> no event and drop_cnt_o stays 0; trigger during DRAIN -> drop_cnt_o=1.
REQ-034 Trigger timed so the ring address wraps inside the window -> data still in strict time order.
REQ-035 Reset asserted after the 3rd data word -> wr_en_o=0 from the next cycle and all counters 0; the next event header carries event number 0.
REQ-036 EVENT_FRAMER_TIMESTAMP_EN defined, trigger at cycle 100 after reset -> second word = 64'd100 and 10 words total.
